snax_tcdm_read_aligner: RTL and testbench
=========================================

# snax_tcdm_read_aligner

Narrow-to-wide lane aligner between the SNAX HWPE-to-reqrsp converter (32-bit word requests) and the 64-bit TCDM reqrsp port. It aligns addresses down to the TCDM word and steers write data and strobes into the addressed lane. It records the lane and type of every accepted request in an in-order tracker, and returns the correct 32-bit word of each read response. It also caps outstanding transactions at `MaxOutstanding` by back-pressuring the narrow side.

## Interface
- `AddrWidth`, 48, address width on both sides
- `DataWidth`, 64, TCDM (wide) data width; `DataWidth/WordWidth` = R, a power of two ≥ 1
- `WordWidth`, 32, narrow data width
- `MaxOutstanding`, 8, tracker depth = max in-flight requests (≥ 2)
- `clk_i` in 1 — clock
- `rst_i` in 1 — reset, asynchronous, active-high
- `in_q_valid_i` in 1 — narrow request valid
- `in_q_ready_o` out 1 — narrow request ready
- `in_q_addr_i` in AddrWidth — byte address, word-aligned
- `in_q_write_i` in 1 — 1 = write, 0 = read
- `in_q_data_i` in WordWidth — write data
- `in_q_strb_i` in WordWidth/8 — byte strobes
- `in_p_valid_o` out 1 — narrow read response valid (no backpressure)
- `in_p_data_o` out WordWidth — selected read word
- `out_q_valid_o` out 1 — wide request valid
- `out_q_ready_i` in 1 — wide request ready
- `out_q_addr_o` out AddrWidth — aligned address
- `out_q_write_o` out 1 — write flag
- `out_q_data_o` out DataWidth — lane-replicated write data
- `out_q_strb_o` out DataWidth/8 — lane-steered strobes
- `out_p_valid_i` in 1 — wide response valid, one per accepted request, in order
- `out_p_data_i` in DataWidth — wide response data
- `outstanding_o` out $clog2(MaxOutstanding+1) — in-flight count

## Operation
- Lane index L = `in_q_addr_i[$clog2(DataWidth/8)-1 : $clog2(WordWidth/8)]`. When R = 1, L = 0.
- Request path is combinational, with no added latency:
  - `out_q_valid_o` = `in_q_valid_i & !full`
  - `in_q_ready_o` = `out_q_ready_i & !full`
  - `out_q_addr_o` = `in_q_addr_i` with its low $clog2(DataWidth/8) bits zeroed
  - `out_q_write_o` = `in_q_write_i`
  - `out_q_data_o` = `in_q_data_i` replicated R times
  - `out_q_strb_o` = `in_q_strb_i` placed at lane L, zeros elsewhere; strobes apply to writes and pass through unchanged in form on reads
- Accept is `out_q_valid_o & out_q_ready_i`. On accept, push the entry {write, L} into the tracker.
- When `out_p_valid_i` is high and the tracker is non-empty, pop the head entry:
  - Read entry: next cycle `in_p_valid_o`=1 and `in_p_data_o` = `out_p_data_i[L*WordWidth +: WordWidth]`.
  - Write entry: the response is consumed; `in_p_valid_o` stays 0.
- When `out_p_valid_i` is high and the tracker is empty, the response is spurious. It is dropped with no pop and no output.
- `outstanding_o` = tracker occupancy. It is +1 on accept, −1 on pop, and unchanged when both happen in the same cycle.

## Timing
- Reset values: `in_p_valid_o`=0, `in_p_data_o`=0, `outstanding_o`=0, tracker empty. `out_q_valid_o` and `in_q_ready_o` follow their combinational equations.
- Request latency is 0 cycles. Response latency is exactly 1 cycle, registered.
- `in_p_data_o` holds its last value when `in_p_valid_o`=0.
- Full is the registered occupancy == MaxOutstanding. A pop in the same cycle does not unblock accept; the push resumes the next cycle.
- The tracker is not fall-through. A response in the same cycle as the accept of the only entry is treated as spurious, because TCDM latency is ≥ 1.
- Reset asserted mid-operation clears the tracker and the response register asynchronously. Responses arriving after reset deassertion for pre-reset requests are treated as spurious.
- Once `in_q_valid_i` is asserted, upstream holds it and its payload stable until `in_q_ready_o`; this block relies on that.

## Configuration
- `SNAX_TCDM_ALIGNER_ERR_EN`
  - Defined: adds output port `err_o` (1 bit). It resets to 0, is set sticky on any spurious response, and is cleared only by `rst_i`.
  - Undefined: the port is absent and spurious responses are dropped silently.

## Structure
- Package `snax_tcdm_align_pkg` holds:
  - the `tracker_entry_t` typedef {write, lane}
  - the localparams for lane width and counter width as functions of the parameters
- Sub-module: the tracker is one `fifo_v3` from common_cells (dtype `tracker_entry_t`, DEPTH `MaxOutstanding`, `flush_i`=`rst_i`-independent 0). Its `usage_o` extended by its full flag drives `outstanding_o`.

## Test plan
- Read 0x1000_0004, response data 0x1234_ABCD_DEAD_BEEF → `out_q_addr_o`=0x1000_0000, one cycle after the response `in_p_valid_o`=1 and `in_p_data_o`=0x1234_ABCD.
- Write 0xC0DE_BABE, strb 0xF, to 0x1000_000C → `out_q_addr_o`=0x1000_0008, `out_q_data_o`=0xC0DE_BABE_C0DE_BABE, `out_q_strb_o`=0xF0; its response gives no `in_p_valid_o`.
- Issue 8 reads with responses withheld → `outstanding_o`=8, `in_q_ready_o`=0. A 9th read stalls until one cycle after the first response.
- Interleave reads to 0x0, 0x4, 0x8, write to 0xC, read to 0x4; return in order with distinct data → exactly 4 narrow responses, each with the correct lane word in order.
- `out_p_valid_i` pulsed with an empty tracker → no `in_p_valid_o`, `outstanding_o` stays 0; with `SNAX_TCDM_ALIGNER_ERR_EN`, `err_o`=1 and it stays 1 until `rst_i`.
- Assert `rst_i` with 3 requests outstanding → `outstanding_o`=0 immediately; later responses yield no `in_p_valid_o`.

Source files
------------

// File: rtl/snax_tcdm_align_pkg.sv
// Shared types and sizing helpers for the SNAX TCDM narrow-to-wide read aligner.
package snax_tcdm_align_pkg;

    localparam int unsigned DefDataWidth      = 64;
    localparam int unsigned DefWordWidth      = 32;
    localparam int unsigned DefMaxOutstanding = 8;

    // Lane index width; a single-lane configuration still keeps one bit.
    function automatic int unsigned lane_bits(input int unsigned data_w,
                                              input int unsigned word_w);
        int unsigned ratio;
        ratio = data_w / word_w;
        return (ratio > 1) ? $clog2(ratio) : 1;
    endfunction

    function automatic int unsigned cnt_bits(input int unsigned max_out);
        return $clog2(max_out + 1);
    endfunction

    localparam int unsigned LaneWidth = lane_bits(DefDataWidth, DefWordWidth);

    typedef struct packed {
        logic                 write;
        logic [LaneWidth-1:0] lane;
    } tracker_entry_t;

endpackage

// File: rtl/fifo_v3.sv
// Synchronous FIFO with the common_cells fifo_v3 interface (no fall-through), used as an
// in-order request tracker.
module fifo_v3 #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 8,
    parameter type         dtype      = logic [DATA_WIDTH-1:0],
    parameter int unsigned ADDR_DEPTH = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [ADDR_DEPTH-1:0] usage_o,
    input  dtype                  data_i,
    input  logic                  push_i,
    output dtype                  data_o,
    input  logic                  pop_i
);

    logic [ADDR_DEPTH-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [ADDR_DEPTH:0]   cnt_q, cnt_d;
    logic                  push_ok, pop_ok;
    dtype                  mem_q [DEPTH];

    assign full_o  = (cnt_q == (ADDR_DEPTH+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign usage_o = cnt_q[ADDR_DEPTH-1:0];
    assign data_o  = mem_q[rd_ptr_q];
    assign push_ok = push_i & ~full_o;
    // Pop qualifies on registered empty, so a same-cycle push is never visible.
    assign pop_ok  = pop_i & ~empty_o;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (push_ok) begin
                wr_ptr_d = (wr_ptr_q == ADDR_DEPTH'(DEPTH - 1)) ? '0
                                                                : wr_ptr_q + ADDR_DEPTH'(1);
            end
            if (pop_ok) begin
                rd_ptr_d = (rd_ptr_q == ADDR_DEPTH'(DEPTH - 1)) ? '0
                                                                : rd_ptr_q + ADDR_DEPTH'(1);
            end
            cnt_d = cnt_q + (ADDR_DEPTH+1)'(push_ok) - (ADDR_DEPTH+1)'(pop_ok);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok && !flush_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/snax_tcdm_read_aligner.sv
// Narrow (word) to wide (TCDM) request aligner with in-order read lane selection.
// Define SNAX_TCDM_ALIGNER_ERR_EN to add the sticky err_o flag for spurious responses.
module snax_tcdm_read_aligner
    import snax_tcdm_align_pkg::*;
#(
    parameter int unsigned AddrWidth      = 48,
    parameter int unsigned DataWidth      = DefDataWidth,
    parameter int unsigned WordWidth      = DefWordWidth,
    parameter int unsigned MaxOutstanding = DefMaxOutstanding
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic                                  in_q_valid_i,
    output logic                                  in_q_ready_o,
    input  logic [AddrWidth-1:0]                  in_q_addr_i,
    input  logic                                  in_q_write_i,
    input  logic [WordWidth-1:0]                  in_q_data_i,
    input  logic [WordWidth/8-1:0]                in_q_strb_i,
    output logic                                  in_p_valid_o,
    output logic [WordWidth-1:0]                  in_p_data_o,
    output logic                                  out_q_valid_o,
    input  logic                                  out_q_ready_i,
    output logic [AddrWidth-1:0]                  out_q_addr_o,
    output logic                                  out_q_write_o,
    output logic [DataWidth-1:0]                  out_q_data_o,
    output logic [DataWidth/8-1:0]                out_q_strb_o,
    input  logic                                  out_p_valid_i,
    input  logic [DataWidth-1:0]                  out_p_data_i,
    output logic [cnt_bits(MaxOutstanding)-1:0]   outstanding_o
`ifdef SNAX_TCDM_ALIGNER_ERR_EN
    ,
    output logic                                  err_o
`endif
);

    localparam int unsigned Ratio   = DataWidth / WordWidth;
    localparam int unsigned StrbW   = WordWidth / 8;
    localparam int unsigned OffBits = $clog2(DataWidth / 8);
    localparam int unsigned WordOff = $clog2(WordWidth / 8);
    localparam int unsigned CntW    = cnt_bits(MaxOutstanding);
    localparam int unsigned UsageW  = $clog2(MaxOutstanding);

    logic [LaneWidth-1:0] lane;
    tracker_entry_t       push_entry, head;
    logic                 full, empty, push, pop, rst_n;
    logic [UsageW-1:0]    usage;
    logic [WordWidth-1:0] sel_word;
    logic                 rsp_valid_q;
    logic [WordWidth-1:0] rsp_data_q;

    if (Ratio > 1) begin : g_lane
        assign lane = LaneWidth'(in_q_addr_i[OffBits-1:WordOff]);
    end else begin : g_no_lane
        assign lane = '0;
    end

    // Full is registered occupancy, so a same-cycle pop does not reopen the request path.
    assign out_q_valid_o = in_q_valid_i & ~full;
    assign in_q_ready_o  = out_q_ready_i & ~full;
    assign out_q_addr_o  = in_q_addr_i & ~AddrWidth'((64'd1 << OffBits) - 64'd1);
    assign out_q_write_o = in_q_write_i;
    assign out_q_data_o  = {Ratio{in_q_data_i}};

    always_comb begin
        out_q_strb_o = '0;
        for (int unsigned i = 0; i < Ratio; i++) begin
            if (lane == LaneWidth'(i)) begin
                out_q_strb_o[i*StrbW +: StrbW] = in_q_strb_i;
            end
        end
    end

    assign push             = out_q_valid_o & out_q_ready_i;
    assign pop              = out_p_valid_i & ~empty;
    assign push_entry.write = in_q_write_i;
    assign push_entry.lane  = lane;
    assign rst_n            = ~rst_i;

    fifo_v3 #(
        .DATA_WIDTH ($bits(tracker_entry_t)),
        .DEPTH      (MaxOutstanding),
        .dtype      (tracker_entry_t)
    ) i_tracker (
        .clk_i   (clk_i),
        .rst_ni  (rst_n),
        .flush_i (1'b0),
        .full_o  (full),
        .empty_o (empty),
        .usage_o (usage),
        .data_i  (push_entry),
        .push_i  (push),
        .data_o  (head),
        .pop_i   (pop)
    );

    // The tracker's usage wraps to zero when full, hence the explicit full case.
    assign outstanding_o = full ? CntW'(MaxOutstanding) : CntW'(usage);

    always_comb begin
        sel_word = '0;
        for (int unsigned i = 0; i < Ratio; i++) begin
            if (head.lane == LaneWidth'(i)) begin
                sel_word = out_p_data_i[i*WordWidth +: WordWidth];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            rsp_valid_q <= pop & ~head.write;
            if (pop && !head.write) begin
                rsp_data_q <= sel_word;
            end
        end
    end

    assign in_p_valid_o = rsp_valid_q;
    assign in_p_data_o  = rsp_data_q;

`ifdef SNAX_TCDM_ALIGNER_ERR_EN
    logic err_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_q <= 1'b0;
        end else if (out_p_valid_i && empty) begin
            err_q <= 1'b1;
        end
    end

    assign err_o = err_q;
`endif

endmodule

// File: tb/tb_snax_tcdm_read_aligner.sv
// Directed self-checking bench for snax_tcdm_read_aligner (default 48/64/32/8 configuration).
module tb_snax_tcdm_read_aligner;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        in_q_valid_i = 1'b0;
    logic        in_q_ready_o;
    logic [47:0] in_q_addr_i = '0;
    logic        in_q_write_i = 1'b0;
    logic [31:0] in_q_data_i = '0;
    logic [3:0]  in_q_strb_i = 4'hF;
    logic        in_p_valid_o;
    logic [31:0] in_p_data_o;
    logic        out_q_valid_o;
    logic        out_q_ready_i = 1'b1;
    logic [47:0] out_q_addr_o;
    logic        out_q_write_o;
    logic [63:0] out_q_data_o;
    logic [7:0]  out_q_strb_o;
    logic        out_p_valid_i = 1'b0;
    logic [63:0] out_p_data_i = '0;
    logic [3:0]  outstanding_o;
`ifdef SNAX_TCDM_ALIGNER_ERR_EN
    logic        err_o;
`endif

    int          errors = 0;
    int          checks = 0;
    int          base;
    logic [31:0] rsp_q[$];

    always #5 clk_i = ~clk_i;

    snax_tcdm_read_aligner dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .in_q_valid_i  (in_q_valid_i),
        .in_q_ready_o  (in_q_ready_o),
        .in_q_addr_i   (in_q_addr_i),
        .in_q_write_i  (in_q_write_i),
        .in_q_data_i   (in_q_data_i),
        .in_q_strb_i   (in_q_strb_i),
        .in_p_valid_o  (in_p_valid_o),
        .in_p_data_o   (in_p_data_o),
        .out_q_valid_o (out_q_valid_o),
        .out_q_ready_i (out_q_ready_i),
        .out_q_addr_o  (out_q_addr_o),
        .out_q_write_o (out_q_write_o),
        .out_q_data_o  (out_q_data_o),
        .out_q_strb_o  (out_q_strb_o),
        .out_p_valid_i (out_p_valid_i),
        .out_p_data_i  (out_p_data_i),
        .outstanding_o (outstanding_o)
`ifdef SNAX_TCDM_ALIGNER_ERR_EN
        ,
        .err_o         (err_o)
`endif
    );

    // Collect every narrow response word in arrival order.
    always @(negedge clk_i) begin
        if (in_p_valid_o === 1'b1) rsp_q.push_back(in_p_data_o);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset state
        @(negedge clk_i); #1;
        check("rst_outstanding", outstanding_o, 0);
        check("rst_p_valid", in_p_valid_o, 0);
        check("rst_p_data", in_p_data_o, 0);
        check("rst_q_valid", out_q_valid_o, 0);
        check("rst_q_ready", in_q_ready_o, 1);
`ifdef SNAX_TCDM_ALIGNER_ERR_EN
        check("rst_err", err_o, 0);
`endif
        rst_i = 1'b0;

        // Single read to lane 1
        @(negedge clk_i);
        in_q_valid_i = 1'b1; in_q_addr_i = 48'h1000_0004; in_q_write_i = 1'b0;
        #1;
        check("rd_addr", out_q_addr_o, 48'h1000_0000);
        check("rd_q_valid", out_q_valid_o, 1);
        check("rd_strb", out_q_strb_o, 8'hF0);
        check("rd_write", out_q_write_o, 0);
        @(negedge clk_i);
        in_q_valid_i = 1'b0;
        #1;
        check("rd_outstanding", outstanding_o, 1);
        out_p_valid_i = 1'b1; out_p_data_i = 64'h1234_ABCD_DEAD_BEEF;
        @(negedge clk_i);
        out_p_valid_i = 1'b0;
        #1;
        check("rd_p_valid", in_p_valid_o, 1);
        check("rd_p_data", in_p_data_o, 32'h1234_ABCD);
        check("rd_drained", outstanding_o, 0);
        @(negedge clk_i); #1;
        check("rd_p_valid_low", in_p_valid_o, 0);
        check("rd_p_data_hold", in_p_data_o, 32'h1234_ABCD);

        // Single write to lane 1
        in_q_valid_i = 1'b1; in_q_addr_i = 48'h1000_000C; in_q_write_i = 1'b1;
        in_q_data_i = 32'hC0DE_BABE; in_q_strb_i = 4'hF;
        #1;
        check("wr_addr", out_q_addr_o, 48'h1000_0008);
        check("wr_data", out_q_data_o, 64'hC0DE_BABE_C0DE_BABE);
        check("wr_strb", out_q_strb_o, 8'hF0);
        check("wr_write", out_q_write_o, 1);
        @(negedge clk_i);
        in_q_valid_i = 1'b0; in_q_write_i = 1'b0;
        out_p_valid_i = 1'b1; out_p_data_i = 64'hFFFF_FFFF_FFFF_FFFF;
        @(negedge clk_i);
        out_p_valid_i = 1'b0;
        #1;
        check("wr_no_p_valid", in_p_valid_o, 0);
        check("wr_drained", outstanding_o, 0);

        // Fill the tracker with 8 reads to lane 0
        @(negedge clk_i);
        base = rsp_q.size();
        in_q_valid_i = 1'b1; in_q_addr_i = 48'h0;
        repeat (8) @(negedge clk_i);
        in_q_addr_i = 48'h4;
        #1;
        check("full_outstanding", outstanding_o, 8);
        check("full_q_ready", in_q_ready_o, 0);
        check("full_q_valid", out_q_valid_o, 0);
        out_p_valid_i = 1'b1; out_p_data_i = 64'h0123_4567_89AB_CDEF;
        #1;
        check("full_pop_no_unblock", in_q_ready_o, 0);
        @(negedge clk_i);
        out_p_valid_i = 1'b0;
        #1;
        check("full_after_pop", outstanding_o, 7);
        check("full_resume_ready", in_q_ready_o, 1);
        check("full_first_rsp", in_p_data_o, 32'h89AB_CDEF);
        @(negedge clk_i);
        in_q_valid_i = 1'b0;
        #1;
        check("full_refilled", outstanding_o, 8);
        out_p_valid_i = 1'b1; out_p_data_i = 64'hFEDC_BA98_7654_3210;
        repeat (8) @(negedge clk_i);
        out_p_valid_i = 1'b0;
        @(negedge clk_i); #1;
        check("full_drained", outstanding_o, 0);
        check("full_rsp_count", rsp_q.size() - base, 9);
        check("full_last_lane1", rsp_q[$], 32'hFEDC_BA98);

        // Interleaved reads and a write, responses in order with distinct data
        base = rsp_q.size();
        in_q_valid_i = 1'b1; in_q_write_i = 1'b0; in_q_addr_i = 48'h0;
        @(negedge clk_i); in_q_addr_i = 48'h4;
        @(negedge clk_i); in_q_addr_i = 48'h8;
        @(negedge clk_i); in_q_addr_i = 48'hC; in_q_write_i = 1'b1;
        @(negedge clk_i); in_q_addr_i = 48'h4; in_q_write_i = 1'b0;
        @(negedge clk_i);
        in_q_valid_i = 1'b0;
        #1;
        check("mix_outstanding", outstanding_o, 5);
        for (int k = 0; k < 5; k++) begin
            out_p_valid_i = 1'b1;
            out_p_data_i  = {32'hB000_0000 | 32'(k), 32'hA000_0000 | 32'(k)};
            @(negedge clk_i);
        end
        out_p_valid_i = 1'b0;
        @(negedge clk_i); #1;
        check("mix_rsp_count", rsp_q.size() - base, 4);
        check("mix_rsp0", rsp_q[base], 32'hA000_0000);
        check("mix_rsp1", rsp_q[base + 1], 32'hB000_0001);
        check("mix_rsp2", rsp_q[base + 2], 32'hA000_0002);
        check("mix_rsp3", rsp_q[base + 3], 32'hB000_0004);
        check("mix_drained", outstanding_o, 0);

        // Spurious response with an empty tracker
        base = rsp_q.size();
        out_p_valid_i = 1'b1; out_p_data_i = 64'h1111_2222_3333_4444;
        @(negedge clk_i);
        out_p_valid_i = 1'b0;
        #1;
        check("spur_no_p_valid", in_p_valid_o, 0);
        check("spur_outstanding", outstanding_o, 0);
`ifdef SNAX_TCDM_ALIGNER_ERR_EN
        check("spur_err_set", err_o, 1);
        repeat (3) @(negedge clk_i);
        #1;
        check("spur_err_sticky", err_o, 1);
`endif
        @(negedge clk_i); #1;
        check("spur_rsp_count", rsp_q.size() - base, 0);

        // Reset with three reads in flight
        in_q_valid_i = 1'b1; in_q_addr_i = 48'h0;
        @(negedge clk_i); in_q_addr_i = 48'h4;
        @(negedge clk_i); in_q_addr_i = 48'h8;
        @(negedge clk_i);
        in_q_valid_i = 1'b0;
        #1;
        check("mid_outstanding", outstanding_o, 3);
        rst_i = 1'b1;
        #1;
        check("mid_rst_outstanding", outstanding_o, 0);
        check("mid_rst_p_data", in_p_data_o, 0);
`ifdef SNAX_TCDM_ALIGNER_ERR_EN
        check("mid_rst_err", err_o, 0);
`endif
        @(negedge clk_i);
        rst_i = 1'b0;
        base = rsp_q.size();
        out_p_valid_i = 1'b1; out_p_data_i = 64'h5A5A_5A5A_A5A5_A5A5;
        repeat (3) @(negedge clk_i);
        out_p_valid_i = 1'b0;
        @(negedge clk_i); #1;
        check("mid_late_rsp_count", rsp_q.size() - base, 0);
        check("mid_late_outstanding", outstanding_o, 0);
`ifdef SNAX_TCDM_ALIGNER_ERR_EN
        check("mid_late_err", err_o, 1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
